// File: rtl/y86_pkg.sv
// Y86-64 fetch shared definitions: opcode values, fetch FSM states, "no register" code.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Register specifier meaning "no register"; also what absent rA/rB read as.
    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYTE0,
        S_REGS,
        S_CONST,
        S_DONE
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: PC request handshake, byte-wide instruction memory port, fetch result.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on the request side; memory answers with mem_rvalid.
interface fetch_unit_if #(parameter int ADDR_W = 64);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] pc_in;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              mem_rvalid;
    logic              mem_err;

    logic              out_valid;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic [63:0]       valC;
    logic [ADDR_W-1:0] valP;
    logic              instr_invalid;
    logic              imem_error;

    // The fetch unit itself.
    modport slave (
        input  req_valid, pc_in, mem_rdata, mem_rvalid, mem_err,
        output req_ready, mem_req, mem_addr,
        output out_valid, icode, ifun, rA, rB, valC, valP, instr_invalid, imem_error
    );

    // PC-update / memory / decode side that talks to the fetch unit.
    modport master (
        output req_valid, pc_in, mem_rdata, mem_rvalid, mem_err,
        input  req_ready, mem_req, mem_addr,
        input  out_valid, icode, ifun, rA, rB, valC, valP, instr_invalid, imem_error
    );

endinterface

// File: rtl/instr_len_decode.sv
// Y86-64 opcode classifier: which optional fields (register byte, 8-byte constant) follow byte 0.
// Latency: purely combinational.
// Backpressure: none.
module instr_len_decode
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    output logic       o_need_regs,
    output logic       o_need_valc,
    output logic       o_invalid
);

    // Length is 1 + need_regs + 8*need_valc; unknown opcodes are one byte long.
    always_comb begin
        o_need_regs = 1'b0;
        o_need_valc = 1'b0;
        o_invalid   = 1'b0;
        case (i_icode)
            I_HALT, I_NOP, I_RET: begin
            end
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                o_need_regs = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                o_need_regs = 1'b1;
                o_need_valc = 1'b1;
            end
            I_JXX, I_CALL: begin
                o_need_valc = 1'b1;
            end
            default: begin
                o_invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Y86-64 byte-serial instruction fetch; optional FETCH_HALT_LOCK_EN freezes after halt/error fetches.
// Latency: N-byte instruction, zero-wait memory: out_valid N+1 cycles after accept, +1 per wait cycle.
// Backpressure: one fetch in flight; req_ready only in idle; memory stalls via mem_rvalid.
module fetch_unit
    import y86_pkg::*;
#(
    parameter int ADDR_W = 64
)
(
    input logic        clk,
    input logic        rst_n,
    fetch_unit_if.slave bus
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_valp;
    logic [3:0]        r_k;          // bytes captured so far in this fetch
    logic [2:0]        r_cidx;       // next constant byte index
    logic [3:0]        r_icode;
    logic [3:0]        r_ifun;
    logic [3:0]        r_ra;
    logic [3:0]        r_rb;
    logic [63:0]       r_valc;
    logic [55:0]       r_cbuf;       // constant bytes 0..6 collected before the last one
    logic              r_need_valc;
    logic              r_invalid;
    logic              r_imem_error;
    logic              r_out_valid;

    logic              w_accept;
    logic              w_capture;
    logic              w_fault;
    logic              w_byte_state;
    logic              w_rsp;
    logic              w_req_ready;
    logic              w_locked;
    logic              w_dec_need_regs;
    logic              w_dec_need_valc;
    logic              w_dec_invalid;

    // Byte 0 is classified straight off the memory bus so the next state is known at capture.
    instr_len_decode u_len_dec (
        .i_icode     (bus.mem_rdata[7:4]),
        .o_need_regs (w_dec_need_regs),
        .o_need_valc (w_dec_need_valc),
        .o_invalid   (w_dec_invalid)
    );

`ifdef FETCH_HALT_LOCK_EN
    logic r_lock;

    // Latch the frozen status once a halt, invalid or faulting fetch has been reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock <= 1'b0;
        end else if ((r_state == S_DONE) &&
                     ((r_icode == I_HALT) || r_invalid || r_imem_error)) begin
            r_lock <= 1'b1;
        end
    end

    assign w_locked = r_lock;
`else
    assign w_locked = 1'b0;
`endif

    assign w_byte_state = (r_state == S_BYTE0) || (r_state == S_REGS) || (r_state == S_CONST);
    assign w_rsp        = w_byte_state && bus.mem_rvalid;
    // Not ready while the result pulse is out, so req_ready follows out_valid by a cycle.
    assign w_req_ready  = (r_state == S_IDLE) && !r_out_valid && !w_locked;

    assign bus.req_ready     = w_req_ready;
    assign bus.mem_req       = w_byte_state;
    assign bus.mem_addr      = w_byte_state ? (r_base + ADDR_W'(r_k)) : '0;
    assign bus.out_valid     = r_out_valid;
    assign bus.icode         = r_icode;
    assign bus.ifun          = r_ifun;
    assign bus.rA            = r_ra;
    assign bus.rB            = r_rb;
    assign bus.valC          = r_valc;
    assign bus.valP          = r_valp;
    assign bus.instr_invalid = r_invalid;
    assign bus.imem_error    = r_imem_error;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the accept/capture/fault strobes that steer the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_fault     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid && w_req_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BYTE0;
                end
            end
            S_BYTE0: begin
                if (w_rsp) begin
                    if (bus.mem_err) begin
                        w_fault     = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_capture = 1'b1;
                        if (w_dec_need_regs) begin
                            w_state_nxt = S_REGS;
                        end else if (w_dec_need_valc) begin
                            w_state_nxt = S_CONST;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
            end
            S_REGS: begin
                if (w_rsp) begin
                    if (bus.mem_err) begin
                        w_fault     = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = r_need_valc ? S_CONST : S_DONE;
                    end
                end
            end
            S_CONST: begin
                if (w_rsp) begin
                    if (bus.mem_err) begin
                        w_fault     = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_capture = 1'b1;
                        if (r_cidx == 3'd7) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Fetch datapath: clear fields on accept, fill them byte by byte, publish valP at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base       <= '0;
            r_valp       <= '0;
            r_k          <= '0;
            r_cidx       <= '0;
            r_icode      <= '0;
            r_ifun       <= '0;
            r_ra         <= REG_NONE;
            r_rb         <= REG_NONE;
            r_valc       <= '0;
            r_cbuf       <= '0;
            r_need_valc  <= 1'b0;
            r_invalid    <= 1'b0;
            r_imem_error <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_out_valid <= (r_state == S_DONE);

            if (w_accept) begin
                r_base       <= bus.pc_in;
                r_k          <= '0;
                r_cidx       <= '0;
                r_icode      <= '0;
                r_ifun       <= '0;
                r_ra         <= REG_NONE;
                r_rb         <= REG_NONE;
                r_valc       <= '0;
                r_cbuf       <= '0;
                r_need_valc  <= 1'b0;
                r_invalid    <= 1'b0;
                r_imem_error <= 1'b0;
            end

            if (w_capture) begin
                r_k <= r_k + 4'd1;
                case (r_state)
                    S_BYTE0: begin
                        r_icode     <= bus.mem_rdata[7:4];
                        r_ifun      <= bus.mem_rdata[3:0];
                        r_invalid   <= w_dec_invalid;
                        r_need_valc <= w_dec_need_valc;
                    end
                    S_REGS: begin
                        r_ra <= bus.mem_rdata[7:4];
                        r_rb <= bus.mem_rdata[3:0];
                    end
                    S_CONST: begin
                        // Little-endian: bytes shift down so constant byte 0 ends in bits 7:0.
                        r_cidx <= r_cidx + 3'd1;
                        r_cbuf <= {bus.mem_rdata, r_cbuf[55:8]};
                        // valC only appears once complete; a faulted constant reads as zero.
                        if (r_cidx == 3'd7) begin
                            r_valc <= {bus.mem_rdata, r_cbuf};
                        end
                    end
                    default: begin
                    end
                endcase
            end

            if (w_fault) begin
                r_imem_error <= 1'b1;
            end

            // Bytes captured + 1: the full length on success, one past the good bytes on a fault.
            if (w_rsp && (w_state_nxt == S_DONE)) begin
                r_valp <= r_base + ADDR_W'(r_k) + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cases plus random instructions against a reference model.
// Latency: checks exact accept-to-out_valid cycle counts including memory wait cycles.
// Backpressure: memory model inserts a fixed number of wait cycles per byte for each fetch.
module tb_fetch_unit;

    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    fetch_unit_if #(.ADDR_W(64)) bus ();

    fetch_unit #(.ADDR_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        inv;
        logic        err;
        int          lat;
    } exp_t;

    // Memory model state
    logic [7:0]  mem [logic [63:0]];
    logic        err_en   = 1'b0;
    logic [63:0] err_addr = '0;
    int          cur_wait = 0;
    int          rsp_cnt  = 0;

    // Expectation handed from driver to monitor
    exp_t        expc;
    bit          exp_pend = 1'b0;
    int          t_acc    = 0;

    // Last DUT result seen by the monitor (for hand-computed checks)
    logic [3:0]  last_icode, last_ifun, last_ra, last_rb;
    logic [63:0] last_valc, last_valp;
    logic        last_inv, last_err;
    int          last_lat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nominal_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 9;
            4'h3, 4'h4, 4'h5:       return 10;
            default:                return 1;
        endcase
    endfunction

    // What the fetch must report, given the instruction bytes, where (if anywhere) memory faults,
    // and the wait cycles per byte.
    function automatic exp_t model(input logic [63:0] pc, input logic [79:0] b,
                                   input int errpos, input int w);
        exp_t e;
        int   len     = nominal_len(b[7:4]);
        int   cap     = (errpos >= 0) ? errpos : len;
        int   fetched = (errpos >= 0) ? errpos + 1 : len;
        bit   regs    = (len == 2) || (len == 10);
        e.icode = (cap >= 1) ? b[7:4] : 4'h0;
        e.ifun  = (cap >= 1) ? b[3:0] : 4'h0;
        e.inv   = (cap >= 1) && (b[7:4] > 4'hB);
        e.ra    = (regs && cap >= 2) ? b[15:12] : 4'hF;
        e.rb    = (regs && cap >= 2) ? b[11:8]  : 4'hF;
        e.valc  = '0;
        if (len >= 9 && cap == len) begin
            for (int j = 0; j < 8; j++) e.valc[8*j +: 8] = b[8*(len-8+j) +: 8];
        end
        e.valp = pc + 64'(fetched);
        e.err  = (errpos >= 0);
        e.lat  = fetched * (w + 1) + 1;
        return e;
    endfunction

    // Memory responder: W wait cycles per byte, then data; noise on rvalid/err when not requested.
    initial begin
        int  cnt      = 0;
        bit  prev_req = 0;
        bit  prev_rsp = 0;
        logic [63:0] a;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_err    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && bus.mem_req) begin
                if (!prev_req || prev_rsp) cnt = cur_wait;
                if (cnt == 0) begin
                    a              = bus.mem_addr;
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = mem.exists(a) ? mem[a] : 8'h5A;
                    bus.mem_err    = err_en && (a == err_addr);
                    prev_rsp       = 1;
                    rsp_cnt++;
                end else begin
                    cnt--;
                    bus.mem_rvalid = 1'b0;
                    bus.mem_rdata  = 8'($urandom);
                    bus.mem_err    = 1'($urandom);
                    prev_rsp       = 0;
                end
                prev_req = 1;
            end else begin
                bus.mem_rvalid = 1'($urandom);
                bus.mem_rdata  = 8'($urandom);
                bus.mem_err    = 1'($urandom);
                prev_req       = 0;
                prev_rsp       = 0;
            end
        end
    end

    // Compare process: every out_valid pulse must match exactly one pending expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && bus.out_valid) begin
                last_icode = bus.icode;  last_ifun = bus.ifun;
                last_ra    = bus.rA;     last_rb   = bus.rB;
                last_valc  = bus.valC;   last_valp = bus.valP;
                last_inv   = bus.instr_invalid;
                last_err   = bus.imem_error;
                last_lat   = cyc - t_acc;
                if (!exp_pend) begin
                    chk("unexpected out_valid", {63'd0, bus.out_valid}, 64'd0);
                end else begin
                    chk("icode",         64'(bus.icode), 64'(expc.icode));
                    chk("ifun",          64'(bus.ifun),  64'(expc.ifun));
                    chk("rA",            64'(bus.rA),    64'(expc.ra));
                    chk("rB",            64'(bus.rB),    64'(expc.rb));
                    chk("valC",          bus.valC,       expc.valc);
                    chk("valP",          bus.valP,       expc.valp);
                    chk("instr_invalid", 64'(bus.instr_invalid), 64'(expc.inv));
                    chk("imem_error",    64'(bus.imem_error),    64'(expc.err));
                    chk("latency",       64'(cyc - t_acc),       64'(expc.lat));
                    exp_pend = 1'b0;
                end
            end
        end
    end

    task automatic chk_reset();
        chk("rst req_ready",  64'(bus.req_ready), 64'd1);
        chk("rst mem_req",    64'(bus.mem_req),   64'd0);
        chk("rst mem_addr",   bus.mem_addr,       64'd0);
        chk("rst out_valid",  64'(bus.out_valid), 64'd0);
        chk("rst icode",      64'(bus.icode),     64'd0);
        chk("rst ifun",       64'(bus.ifun),      64'd0);
        chk("rst rA",         64'(bus.rA),        64'hF);
        chk("rst rB",         64'(bus.rB),        64'hF);
        chk("rst valC",       bus.valC,           64'd0);
        chk("rst valP",       bus.valP,           64'd0);
        chk("rst invalid",    64'(bus.instr_invalid), 64'd0);
        chk("rst imem_error", 64'(bus.imem_error),    64'd0);
    endtask

    // Entered and left at posedge+2.
    task automatic pulse_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic load_mem(input logic [63:0] pc, input logic [79:0] b, input int errpos, input int w);
        mem.delete();
        for (int i = 0; i < 10; i++) mem[pc + 64'(i)] = b[8*i +: 8];
        err_en   = (errpos >= 0);
        err_addr = pc + 64'(errpos);
        cur_wait = w;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
    endtask

    // One complete fetch; entered and left at posedge+2.
    task automatic run_fetch(input logic [63:0] pc, input logic [79:0] b, input int errpos, input int w);
        int n;
        bit lockc;
        load_mem(pc, b, errpos, w);
        expc = model(pc, b, errpos, w);
        wait_ready();
        if (!bus.req_ready) begin
            chk("req_ready wait", 64'(bus.req_ready), 64'd1);
            return;
        end
        bus.pc_in     = pc;
        bus.req_valid = 1'b1;
        exp_pend      = 1'b1;
        @(posedge clk);
        #2;
        t_acc = cyc;
        n     = 0;
        // Requests while busy must be ignored.
        while (exp_pend && n < 200) begin
            bus.req_valid = 1'($urandom);
            bus.pc_in     = {$urandom, $urandom};
            @(posedge clk);
            #2;
            n++;
        end
        bus.req_valid = 1'b0;
        if (exp_pend) begin
            chk("out_valid timeout", 64'(bus.out_valid), 64'd1);
            exp_pend = 1'b0;
            pulse_reset();
            return;
        end
        chk("req_ready during out_valid", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #2;
        chk("out_valid one cycle", 64'(bus.out_valid), 64'd0);
        lockc = (expc.icode == 4'h0) || expc.inv || expc.err;
`ifdef FETCH_HALT_LOCK_EN
        if (lockc) begin
            chk("locked req_ready", 64'(bus.req_ready), 64'd0);
            repeat (3) @(posedge clk);
            #2;
            chk("still locked req_ready", 64'(bus.req_ready), 64'd0);
            pulse_reset();
        end else begin
            chk("req_ready back", 64'(bus.req_ready), 64'd1);
        end
`else
        if (lockc) chk("req_ready back after halt/err", 64'(bus.req_ready), 64'd1);
        else       chk("req_ready back", 64'(bus.req_ready), 64'd1);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        logic [79:0] b;
        logic [63:0] pc;
        int len, ep, w;

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.pc_in     = '0;
        repeat (3) @(posedge clk);
        #2;
        chk_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // halt at 0, zero wait
        run_fetch(64'd0, 80'h00, -1, 0);
        chk("halt latency", 64'(last_lat),  64'd2);
        chk("halt icode",   64'(last_icode), 64'd0);
        chk("halt valP",    last_valp,       64'd1);
        chk("halt rA",      64'(last_ra),    64'hF);
        chk("halt valC",    last_valc,       64'd0);

        // irmovq $0x0807060504030201, %rbx at 2
        run_fetch(64'd2, 80'h0807060504030201_F3_30, -1, 0);
        chk("irmovq icode", 64'(last_icode), 64'd3);
        chk("irmovq rB",    64'(last_rb),    64'd3);
        chk("irmovq valC",  last_valc,       64'h0807060504030201);
        chk("irmovq valP",  last_valp,       64'd12);

        // jXX (73) at 16 with two wait cycles per byte
        run_fetch(64'd16, 80'h00_8877665544332211_73, -1, 2);
        chk("jxx ifun",    64'(last_ifun), 64'd3);
        chk("jxx valC",    last_valc,      64'h8877665544332211);
        chk("jxx valP",    last_valp,      64'd25);
        chk("jxx latency", 64'(last_lat),  64'd28);

        // mrmovq with a fault on the 4th byte
        run_fetch(64'd100, 80'h0807060504030201_12_50, 3, 0);
        chk("mrmovq err",  64'(last_err), 64'd1);
        chk("mrmovq valC", last_valc,     64'd0);
        chk("mrmovq valP", last_valp,     64'd104);

        // invalid opcode: one byte, one memory read
        r0 = rsp_cnt;
        run_fetch(64'd40, 80'hC0, -1, 0);
        chk("invalid flag",  64'(last_inv),      64'd1);
        chk("invalid valP",  last_valp,          64'd41);
        chk("invalid reads", 64'(rsp_cnt - r0),  64'd1);

        // reset during the constant phase abandons the fetch
        load_mem(64'd200, 80'h1122334455667788_F3_30, -1, 1);
        wait_ready();
        bus.pc_in     = 64'd200;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        chk("abort mem_req before reset", 64'(bus.mem_req), 64'd1);
        pulse_reset();
        repeat (4) @(posedge clk);
        #2;
        run_fetch(64'd200, 80'h1122334455667788_F3_30, -1, 0);
        chk("post-abort valC", last_valc, 64'h1122334455667788);
        chk("post-abort valP", last_valp, 64'd210);

        // address wrap
        run_fetch(64'hFFFF_FFFF_FFFF_FFFC, 80'h0807060504030201_AB_80, -1, 0);
        chk("wrap valP", last_valp, 64'h0000_0000_0000_0005);

        // random instructions
        for (int t = 0; t < 300; t++) begin
            b   = {16'($urandom), $urandom, $urandom};
            len = nominal_len(b[7:4]);
            ep  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            w   = int'($urandom_range(0, 2));
            pc  = ($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 9)))
                                              : {$urandom, $urandom};
            run_fetch(pc, b, ep, w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Sequential Y86-64 instruction fetch engine on the consumer side of the PC-update path. It accepts the next PC produced by PC update and reads the instruction byte-by-byte over a narrow instruction-memory port. It then decodes the length and delivers icode, ifun, rA, rB, valC and valP to decode/execute. Invalid opcodes and memory faults are reported as status flags.

## Interface
- ADDR_W, 64, PC and memory address width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  new PC presented on pc_in
- req_ready  out  1  high only in IDLE; request accepted on clk edge with req_valid & req_ready
- pc_in  in  ADDR_W  PC to fetch (from PC update's pc_updated)
- mem_req  out  1  byte read request, held until mem_rvalid
- mem_addr  out  ADDR_W  byte address, stable while mem_req
- mem_rdata  in  8  read byte, valid with mem_rvalid
- mem_rvalid  in  1  response for current mem_addr; may be high in same cycle as mem_req
- mem_err  in  1  qualifies mem_rvalid: address fault
- out_valid  out  1  one-cycle pulse: fetch result ready
- icode, ifun  out  4 each  byte 0 high/low nibble
- rA, rB  out  4 each  byte 1 high/low nibble; 4'hF when absent
- valC  out  64  little-endian constant; 0 when absent
- valP  out  ADDR_W  pc + instruction length (mod 2^ADDR_W)
- instr_invalid  out  1  icode > 4'hB
- imem_error  out  1  mem_err seen during this fetch

## Operation
- States: IDLE, BYTE0, REGS, CONST, DONE.
- IDLE: req_ready=1. On accept, latch pc_in into base and set byte index k=0. Go to BYTE0.
- Each byte state drives mem_req=1 and mem_addr=base+k. It waits any number of cycles for mem_rvalid. On mem_rvalid with !mem_err, it captures the byte and increments k.
- BYTE0 capture sets icode/ifun and selects the length:
  - 1 byte: 0,1,9; icode > B is also 1 byte, with instr_invalid set.
  - 2 bytes: 2,6,A,B.
  - 9 bytes: 7,8.
  - 10 bytes: 3,4,5.
  - Next state is DONE, REGS or CONST accordingly.
- REGS captures rA/rB. It goes to CONST if the length is 10, else to DONE.
- CONST captures 8 bytes; constant byte j goes to valC[8j+7:8j]. After the 8th byte, go to DONE.
- mem_err with mem_rvalid in any byte state sets imem_error and goes to DONE. Fields not yet fetched read 4'hF/0. valP = base + bytes successfully captured + 1, saturated to the nominal length.
- DONE: out_valid=1 for exactly one cycle, then IDLE. Outputs hold their values until the next accept.
- mem_rvalid outside byte states is ignored. req_valid while busy is ignored (no queuing).
- Address arithmetic wraps modulo 2^ADDR_W.

## Timing
- Reset (async, immediate) takes effect in any state:
  - State goes to IDLE.
  - req_ready=1; mem_req=0; mem_addr=0; out_valid=0.
  - icode=ifun=0; rA=rB=4'hF; valC=0; valP=0.
  - instr_invalid=0; imem_error=0.
- Reset mid-fetch abandons the fetch with no out_valid. A response arriving after reset is ignored.
- Zero-wait memory (mem_rvalid same cycle as mem_req): an accept at edge T and an N-byte instruction capture their bytes at edges T+1..T+N. out_valid is high in the cycle after edge T+N+1 (N+1 cycles from acceptance to the DONE register). req_ready returns one cycle after out_valid.
- Each wait cycle on mem_rvalid adds exactly one cycle.

## Configuration
- FETCH_HALT_LOCK_EN defined: after a fetch completes with icode=0 (halt), instr_invalid or imem_error, the unit stays in IDLE with req_ready=0 until rst_n. This freezes the processor status.
- Undefined: IDLE always has req_ready=1; halt and error fetches are reported only through the flags.

## Structure
- Shared package y86_pkg holds:
  - icode constants (I_HALT..I_POPQ);
  - the state enum;
  - the REG_NONE=4'hF constant.
- Sub-module instr_len_decode: combinational icode -> {need_regs, need_valC, invalid}. It is reusable by the decode stage.

## Test plan
- halt at pc_in=0, byte 8'h00, zero-wait -> out_valid after 2 cycles; icode=0; valP=1; rA=rB=F; valC=0.
- irmovq at pc_in=2, bytes 30 F3 then 0x0102030405060708 (LE) -> icode=3; rB=3; valC=64'h0807060504030201; valP=12.
- jXX (73) at pc_in=16 with 2 wait cycles per byte -> icode=7, ifun=3, valC assembled, valP=25; latency = 10 + 18 cycles.
- mem_err on 4th byte of mrmovq -> imem_error=1; valC=0; out_valid pulses; with FETCH_HALT_LOCK_EN, req_ready stays 0 until reset.
- byte 8'hC0 -> instr_invalid=1; valP=pc+1; single memory read.
- rst_n low during CONST -> mem_req drops asynchronously; no out_valid; next request fetches normally.
